// File: rtl/wm_cycle_sequencer_if.sv
// Bundle of the sequencer's control, settings and status signals.
// The appliance controller/bench is the master; the sequencer is the slave.
interface wm_cycle_sequencer_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] wash_in;
  logic [WIDTH-1:0] rinse_in;
  logic [WIDTH-1:0] spin_in;
  logic [WIDTH-1:0] cloth_in;
  logic [2:0]       phase;
  logic [WIDTH-1:0] remaining;
  logic [WIDTH+1:0] total_left;
  logic             motor_on;
  logic             valve_on;
  logic             drain_on;
  logic             door_lock;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output start, pause, abort, wash_in, rinse_in, spin_in, cloth_in,
    input  phase, remaining, total_left, motor_on, valve_on, drain_on,
           door_lock, busy, done, error
  );

  modport slave (
    input  start, pause, abort, wash_in, rinse_in, spin_in, cloth_in,
    output phase, remaining, total_left, motor_on, valve_on, drain_on,
           door_lock, busy, done, error
  );
endinterface

// File: rtl/wm_cycle_sequencer.sv
// Timed run-cycle sequencer for one washing machine.
// Steps WASH -> RINSE -> SPIN -> DONE (skipping zero-time phases), with
// pause/abort handling, an abort drain phase, and registered actuator outputs.
module wm_cycle_sequencer #(
  parameter int WIDTH      = 5,
  parameter int TICK_DIV   = 4,
  parameter int CLOTH_MAX  = 20,
  parameter int DRAIN_TIME = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  wm_cycle_sequencer_if.slave   bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WASH  = 3'd1,
    S_RINSE = 3'd2,
    S_SPIN  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } phase_t;

  phase_t           state, state_n;
  logic [PW-1:0]    presc, presc_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic [WIDTH+1:0] total, total_n;
  logic [WIDTH-1:0] rinse_q, rinse_n;
  logic [WIDTH-1:0] spin_q, spin_n;
  logic             error_q, error_n;

  logic motor_q, motor_n;
  logic valve_q, valve_n;
  logic drain_q, drain_n;
  logic lock_q, lock_n;
  logic busy_q, busy_n;
  logic done_q, done_n;

  logic tick;
  logic hold;
  logic cloth_ok;

  assign tick     = (presc == PW'(TICK_DIV - 1));
  assign cloth_ok = (bus.cloth_in != '0) && (int'(bus.cloth_in) <= CLOTH_MAX);

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      presc   <= '0;
      rem     <= '0;
      total   <= '0;
      rinse_q <= '0;
      spin_q  <= '0;
      error_q <= 1'b0;
      motor_q <= 1'b0;
      valve_q <= 1'b0;
      drain_q <= 1'b0;
      lock_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      rem     <= rem_n;
      total   <= total_n;
      rinse_q <= rinse_n;
      spin_q  <= spin_n;
      error_q <= error_n;
      motor_q <= motor_n;
      valve_q <= valve_n;
      drain_q <= drain_n;
      lock_q  <= lock_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Next-state, countdown and next-output logic.
  // Outputs are derived from the next state so they line up with phase after each edge.
  always_comb begin
    state_n = state;
    presc_n = presc;
    rem_n   = rem;
    total_n = total;
    rinse_n = rinse_q;
    spin_n  = spin_q;
    error_n = error_q;
    hold    = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (cloth_ok) begin
            error_n = 1'b0;
            rinse_n = bus.rinse_in;
            spin_n  = bus.spin_in;
            presc_n = '0;
            total_n = (WIDTH+2)'(bus.wash_in) + (WIDTH+2)'(bus.rinse_in)
                    + (WIDTH+2)'(bus.spin_in);
            if (bus.wash_in != '0) begin
              state_n = S_WASH;
              rem_n   = bus.wash_in;
            end else if (bus.rinse_in != '0) begin
              state_n = S_RINSE;
              rem_n   = bus.rinse_in;
            end else if (bus.spin_in != '0) begin
              state_n = S_SPIN;
              rem_n   = bus.spin_in;
            end else begin
              state_n = S_DONE;
              rem_n   = '0;
            end
          end else begin
            error_n = 1'b1;
          end
        end
      end

      S_WASH, S_RINSE, S_SPIN: begin
        if (bus.abort) begin
          state_n = S_DRAIN;
          presc_n = '0;
          rem_n   = WIDTH'(DRAIN_TIME);
          total_n = (WIDTH+2)'(DRAIN_TIME);
        end else if (bus.pause) begin
          hold = 1'b1;
        end else if (tick) begin
          presc_n = '0;
          total_n = total - 1'b1;
          if (rem == WIDTH'(1)) begin
            // Phase exhausted: jump to the next phase with a nonzero time, else DONE.
            state_n = S_DONE;
            rem_n   = '0;
            if (state == S_WASH && rinse_q != '0) begin
              state_n = S_RINSE;
              rem_n   = rinse_q;
            end else if (state != S_SPIN && spin_q != '0) begin
              state_n = S_SPIN;
              rem_n   = spin_q;
            end
          end else begin
            rem_n = rem - 1'b1;
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end

      S_DRAIN: begin
        if (tick) begin
          presc_n = '0;
          rem_n   = rem - 1'b1;
          total_n = total - 1'b1;
          if (rem == WIDTH'(1)) begin
            state_n = S_IDLE;
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
        presc_n = '0;
        rem_n   = '0;
        total_n = '0;
      end
    endcase

    motor_n = (state_n inside {S_WASH, S_RINSE, S_SPIN}) && !hold;
    valve_n = (state_n inside {S_WASH, S_RINSE}) && !hold;
    drain_n = ((state_n == S_SPIN) && !hold) || (state_n == S_DRAIN);
    lock_n  = state_n inside {S_WASH, S_RINSE, S_SPIN, S_DRAIN};
    busy_n  = state_n inside {S_WASH, S_RINSE, S_SPIN, S_DRAIN};
    done_n  = (state_n == S_DONE);
  end

  assign bus.phase      = state;
  assign bus.remaining  = rem;
  assign bus.total_left = total;
  assign bus.motor_on   = motor_q;
  assign bus.valve_on   = valve_q;
  assign bus.drain_on   = drain_q;
  assign bus.door_lock  = lock_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_wm_cycle_sequencer.sv
// Scoreboard bench for wm_cycle_sequencer: a timeline-based reference model
// pushes the expected post-edge outputs; a monitor pops and compares each cycle.
module tb_wm_cycle_sequencer;

  localparam int W          = 5;
  localparam int TD         = 4;
  localparam int CLOTH_MAX  = 20;
  localparam int DRAIN_TIME = 2;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  typedef struct packed {
    logic [2:0]   phase;
    logic [W-1:0] remaining;
    logic [W+1:0] total_left;
    logic         motor_on;
    logic         valve_on;
    logic         drain_on;
    logic         door_lock;
    logic         busy;
    logic         done;
    logic         error;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wm_cycle_sequencer_if #(.WIDTH(W)) bus ();

  wm_cycle_sequencer #(
    .WIDTH(W),
    .TICK_DIV(TD),
    .CLOTH_MAX(CLOTH_MAX),
    .DRAIN_TIME(DRAIN_TIME)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  snap_t expq[$];

  // Settings presented on the bus.
  int set_w, set_r, set_s, set_c;

  // Reference model: a run is a list of nonzero segments and a count of
  // elapsed unpaused cycles; all outputs follow from that by arithmetic.
  int m_mode = M_IDLE;
  int m_units[$];
  int m_phases[$];
  int m_e, m_de;
  bit m_err  = 1'b0;
  bit m_held = 1'b0;

  function automatic int run_cycles();
    int sum = 0;
    foreach (m_units[i]) sum += m_units[i] * TD;
    return sum;
  endfunction

  function automatic snap_t expect_now();
    snap_t s;
    int cum, ph, rem, sum;
    bit found;
    s = '0;
    s.error = m_err;
    case (m_mode)
      M_DONE: begin
        s.phase = 3'd5;
        s.done  = 1'b1;
      end
      M_DRAIN: begin
        s.phase      = 3'd4;
        s.remaining  = W'(DRAIN_TIME - m_de / TD);
        s.total_left = (W+2)'(DRAIN_TIME - m_de / TD);
        s.drain_on   = 1'b1;
        s.door_lock  = 1'b1;
        s.busy       = 1'b1;
      end
      M_RUN: begin
        cum = 0; ph = 0; rem = 0; sum = 0; found = 1'b0;
        foreach (m_units[i]) begin
          sum += m_units[i];
          if (!found && m_e < cum + m_units[i] * TD) begin
            found = 1'b1;
            ph    = m_phases[i];
            rem   = m_units[i] - (m_e - cum) / TD;
          end
          cum += m_units[i] * TD;
        end
        s.phase      = 3'(ph);
        s.remaining  = W'(rem);
        s.total_left = (W+2)'(sum - m_e / TD);
        s.motor_on   = !m_held;
        s.valve_on   = !m_held && (ph != 3);
        s.drain_on   = !m_held && (ph == 3);
        s.door_lock  = 1'b1;
        s.busy       = 1'b1;
      end
      default: ;
    endcase
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.phase      = bus.phase;
    s.remaining  = bus.remaining;
    s.total_left = bus.total_left;
    s.motor_on   = bus.motor_on;
    s.valve_on   = bus.valve_on;
    s.drain_on   = bus.drain_on;
    s.door_lock  = bus.door_lock;
    s.busy       = bus.busy;
    s.done       = bus.done;
    s.error      = bus.error;
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("ph=%0d rem=%0d tot=%0d mot=%b val=%b drn=%b lock=%b busy=%b done=%b err=%b",
                     s.phase, s.remaining, s.total_left, s.motor_on, s.valve_on,
                     s.drain_on, s.door_lock, s.busy, s.done, s.error);
  endfunction

  // One clock of stimulus: drive inputs, advance the model, queue the expectation.
  task automatic step(input bit st, input bit pa, input bit ab);
    @(negedge clk);
    bus.start    = st;
    bus.pause    = pa;
    bus.abort    = ab;
    bus.wash_in  = W'(set_w);
    bus.rinse_in = W'(set_r);
    bus.spin_in  = W'(set_s);
    bus.cloth_in = W'(set_c);
    m_held = 1'b0;
    case (m_mode)
      M_IDLE: if (st) begin
        if (set_c >= 1 && set_c <= CLOTH_MAX) begin
          m_err = 1'b0;
          m_units.delete();
          m_phases.delete();
          if (set_w != 0) begin m_units.push_back(set_w); m_phases.push_back(1); end
          if (set_r != 0) begin m_units.push_back(set_r); m_phases.push_back(2); end
          if (set_s != 0) begin m_units.push_back(set_s); m_phases.push_back(3); end
          m_e    = 0;
          m_mode = (m_units.size() > 0) ? M_RUN : M_DONE;
        end else begin
          m_err = 1'b1;
        end
      end
      M_RUN: begin
        if (ab) begin
          m_mode = M_DRAIN;
          m_de   = 0;
        end else if (pa) begin
          m_held = 1'b1;
        end else begin
          m_e++;
          if (m_e == run_cycles()) m_mode = M_DONE;
        end
      end
      M_DRAIN: begin
        m_de++;
        if (m_de == DRAIN_TIME * TD) m_mode = M_IDLE;
      end
      default: m_mode = M_IDLE;
    endcase
    expq.push_back(expect_now());
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    snap_t act;
    act = dut_snap();
    n_vec++;
    if (act !== snap_t'(0)) begin
      n_bad++;
      $display("FAIL %s: got %s, expected all outputs 0", name, fmt(act));
    end
  endtask

  // Assert reset between clock edges and check outputs clear without a clock.
  task automatic mid_cycle_reset(input string name);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero(name);
    expq.delete();
    m_mode = M_IDLE;
    m_err  = 1'b0;
    m_held = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compare DUT outputs against the next queued expectation.
  initial begin
    snap_t exp_s, act;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        exp_s = expq.pop_front();
        act   = dut_snap();
        n_vec++;
        if (act !== exp_s) begin
          n_bad++;
          $display("FAIL outputs @%0t: got %s, expected %s", $time, fmt(act), fmt(exp_s));
        end
      end
    end
  end

  initial begin
    bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0;
    bus.wash_in = '0; bus.rinse_in = '0; bus.spin_in = '0; bus.cloth_in = '0;
    set_w = 0; set_r = 0; set_s = 0; set_c = 0;

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;

    // T1: basic full cycle.
    set_w = 3; set_r = 2; set_s = 1; set_c = 2;
    step(1'b1, 1'b0, 1'b0);
    idle_steps(27);

    // T2: rinse skipped.
    set_w = 2; set_r = 0; set_s = 2; set_c = 7;
    step(1'b1, 1'b0, 1'b0);
    idle_steps(19);

    // T3: pause for 5 cycles partway through WASH.
    set_w = 3; set_r = 2; set_s = 1; set_c = 2;
    step(1'b1, 1'b0, 1'b0);
    idle_steps(5);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
    idle_steps(23);

    // T4: abort in RINSE, then abort/pause ignored in DRAIN.
    step(1'b1, 1'b0, 1'b0);
    idle_steps(14);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    idle_steps(9);

    // T5: load rejection, then acceptance clears error.
    set_c = 0;  step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    set_c = 21; step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    set_c = 5;  set_w = 1; set_r = 1; set_s = 1;
    step(1'b1, 1'b0, 1'b0);
    set_w = 9; set_c = 0;
    idle_steps(14);

    // T6: all times zero, then asynchronous reset mid-SPIN.
    set_w = 0; set_r = 0; set_s = 0; set_c = 3;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle_steps(2);
    set_s = 3;
    step(1'b1, 1'b0, 1'b0);
    idle_steps(5);
    mid_cycle_reset("async_reset_mid_spin");
    idle_steps(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      set_w = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3);
      set_r = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3);
      set_s = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3);
      set_c = $urandom_range(0, 24);
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 99) == 0));
    end

    repeat (2) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
